zrle_unpacker: RTL

//  Consumes a zero-run-length compressed byte stream from the external SRAM FIFO read port.

---
 rtl/zrle_unpacker.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/zrle_unpacker.sv
// Zero-run-length stream unpacker: expands literal / (0x00, R) byte pairs from an
// SRAM FIFO into LANES-wide activation words, one frame of num_elements at a time.
module zrle_unpacker #(
  parameter int LANES          = 8,
  parameter int LOG2_MAX_ELEMS = 16
) (
  input  logic                      clk,
  input  logic                      arst_n_in,
  input  logic                      start,
  input  logic [LOG2_MAX_ELEMS-1:0] num_elements,
  output logic                      busy,
  input  logic [7:0]                fifo_qout,
  input  logic                      fifo_output_valid,
  output logic                      fifo_output_ready,
  output logic [LANES*8-1:0]        out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      protocol_error
);

  localparam int PW = $clog2(LANES);
  localparam int LW = LOG2_MAX_ELEMS;

  typedef enum logic [2:0] {IDLE, LIT, RUNLEN, RUN, FLUSH, DONE} state_t;

  state_t             state, state_nxt;
  logic [LW-1:0]      remaining, rem_nxt;
  logic [8:0]         run, run_nxt;
  logic [PW-1:0]      pos, pos_nxt;
  logic [LANES*8-1:0] pack, pack_nxt;
  logic [1:0][7:0]    skid;
  logic [1:0]         count, ahead;
  logic               inflight, pop, consume, load, err_set, stall, xfer, need, wr_sel;
  logic [8:0]         space, rem_cap, k;
  logic [7:0]         head;

  assign head    = skid[0];
  assign xfer    = out_valid && out_ready;
  assign stall   = out_valid && !out_ready;
  assign space   = 9'(LANES) - 9'(pos);
  assign rem_cap = (32'(remaining) >= 32'd256) ? 9'd256 : 9'(remaining);

  always_comb begin
    k = run;
    if (space < k)   k = space;
    if (rem_cap < k) k = rem_cap;
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = remaining;
    run_nxt   = run;
    pos_nxt   = pos;
    pack_nxt  = pack;
    consume   = 1'b0;
    load      = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: if (start) begin
        pos_nxt  = '0;
        pack_nxt = '0;
        run_nxt  = '0;
        if (num_elements == '0) state_nxt = DONE;
        else begin
          state_nxt = LIT;
          rem_nxt   = num_elements;
        end
      end
      LIT: if (!stall && count != 2'd0) begin
        consume = 1'b1;
        if (head != 8'd0) begin
          pack_nxt[{pos, 3'b000} +: 8] = head;
          pos_nxt = pos + PW'(1);
          rem_nxt = remaining - LW'(1);
          load    = (pos_nxt == '0) || (rem_nxt == '0);
          if (rem_nxt == '0) state_nxt = FLUSH;
        end else begin
          state_nxt = RUNLEN;
        end
      end
      RUNLEN: if (!stall && count != 2'd0) begin
        consume   = 1'b1;
        state_nxt = RUN;
        run_nxt   = 9'(head) + 9'd1;
        // A run longer than the frame is clipped to the frame end.
        if (run_nxt > rem_cap) begin
          run_nxt = rem_cap;
          err_set = 1'b1;
        end
      end
      // Zero lanes need no write: pack is cleared whenever a word leaves.
      RUN: if (!stall) begin
        pos_nxt = pos + PW'(k);
        run_nxt = run - k;
        rem_nxt = remaining - LW'(k);
        load    = (32'(pos) + 32'(k) == LANES) || (rem_nxt == '0);
        if (rem_nxt == '0)      state_nxt = FLUSH;
        else if (run_nxt == '0) state_nxt = LIT;
      end
      FLUSH, DONE: if (xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Only pop bytes the frame is certain to consume, so trailing FIFO data
  // stays untouched; ahead counts bytes buffered after this cycle.
  assign ahead = count + {1'b0, inflight} - {1'b0, consume};

  always_comb begin
    need = 1'b0;
    if (state == LIT || state == RUNLEN || state == RUN) begin
      case (state_nxt)
        LIT:     need = (ahead == 2'd0) ? (rem_nxt != '0)
                                        : (ahead == 2'd1 && 32'(rem_nxt) >= 32'd2);
        RUNLEN:  need = (ahead == 2'd0);
        RUN:     need = (32'(rem_nxt) > 32'(run_nxt)) &&
                        (ahead == 2'd0 ||
                         (ahead == 2'd1 && 32'(rem_nxt) - 32'(run_nxt) >= 32'd2));
        default: need = 1'b0;
      endcase
    end
  end

  assign fifo_output_ready = need;
  assign pop    = fifo_output_valid && fifo_output_ready;
  assign wr_sel = consume ? (count == 2'd2) : (count != 2'd0);

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state          <= IDLE;
      remaining      <= '0;
      run            <= '0;
      pos            <= '0;
      pack           <= '0;
      skid           <= '0;
      count          <= '0;
      inflight       <= 1'b0;
      busy           <= 1'b0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= rem_nxt;
      run       <= run_nxt;
      pos       <= pos_nxt;
      pack      <= load ? '0 : pack_nxt;
      inflight  <= pop;
      count     <= ahead;
      if (consume)  skid[0] <= skid[1];
      if (inflight) skid[wr_sel] <= fifo_qout;
      busy <= (state_nxt != IDLE);
      if (state == IDLE && start) protocol_error <= 1'b0;
      else if (err_set)           protocol_error <= 1'b1;
      if (state == IDLE && start && num_elements == '0) begin
        out_data  <= '0;
        out_valid <= 1'b1;
        out_last  <= 1'b1;
      end else if (load) begin
        out_data  <= pack_nxt;
        out_valid <= 1'b1;
        out_last  <= (rem_nxt == '0);
      end else if (xfer) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
